// File: rtl/clock_disp_pkg.sv
// Shared constants, FSM state type and field helper for the clock display driver.
package clock_disp_pkg;

    localparam int SEC_PER_DAY  = 32'sd86400;
    localparam int SEC_PER_HOUR = 32'sd3600;
    localparam int SEC_PER_MIN  = 32'sd60;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [7:0] FIELD_MAX = 8'd99;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        NORM = 3'd1,
        HRS  = 3'd2,
        MINS = 3'd3,
        BCD  = 3'd4,
        LOAD = 3'd5
    } stateT;

    // A packed date field must fit in two decimal digits.
    function automatic logic fieldBad(input logic [7:0] field);
        return (field > FIELD_MAX);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}; non-BCD codes are blank.
module seg7_decode
    import clock_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Segment lookup
    always_comb begin
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clock_display_driver.sv
// Six-digit time/date display driver with iterative conversion and edit/flash blinking.
// Optional DISPLAY_BLANK_LEAD_ZERO_EN blanks HEX5 when the leftmost field is below 10.
module clock_display_driver
    import clock_disp_pkg::*;
#(
    parameter int BLINK_HALF_PERIOD = 25_000_000
)
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] timeIn,
    input  logic        dateMode,
    input  logic        activeState,
    input  logic [1:0]  editStage,
    input  logic        flashFlag,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic        busy,
    output logic        rangeErr
);

    stateT       state_r;
    logic [31:0] snapTime_r;
    logic        snapDate_r;
    logic [31:0] lastTime_r;
    logic        lastDate_r;
    logic        lastValid_r;
    logic [16:0] work_r;
    logic [6:0]  field_r [0:2];
    logic [3:0]  tens_r  [0:2];
    logic        err_r;
    logic [3:0]  digit_r [0:5];
    logic        dispErr_r;
    logic        dispValid_r;

    logic [31:0] blinkCnt_r;
    logic        blinkVis_r;
    logic [1:0]  prevEdit_r;
    logic        prevActive_r;

    logic [16:0] normSec_s;
    logic        normErr_s;
    logic        dateErr_s;
    logic        changed_s;
    logic        bcdDone_s;
    logic [2:0]  editPair_s;
    logic [5:0]  digBlank_s;
    logic [6:0]  seg_s     [0:5];
    logic [6:0]  hexNext_s [0:5];

    // Fold the signed seconds value into one day, flagging anything outside two days' span
    always_comb begin
        normSec_s = 17'd0;
        normErr_s = 1'b0;
        if ($signed(snapTime_r) < -SEC_PER_DAY) begin
            normErr_s = 1'b1;
        end else if ($signed(snapTime_r) < 32'sd0) begin
            normSec_s = 17'(snapTime_r + 32'(SEC_PER_DAY));
        end else if ($signed(snapTime_r) < SEC_PER_DAY) begin
            normSec_s = 17'(snapTime_r);
        end else if ($signed(snapTime_r) < 2 * SEC_PER_DAY) begin
            normSec_s = 17'(snapTime_r - 32'(SEC_PER_DAY));
        end else begin
            normErr_s = 1'b1;
        end
    end

    // Conversion side conditions
    always_comb begin
        dateErr_s = fieldBad(snapTime_r[23:16]) || fieldBad(snapTime_r[15:8]) ||
                    fieldBad(snapTime_r[7:0]);
        changed_s = !lastValid_r || (timeIn != lastTime_r) || (dateMode != lastDate_r);
        bcdDone_s = (field_r[0] < 7'd10) && (field_r[1] < 7'd10) && (field_r[2] < 7'd10);
    end

    // Conversion FSM: snapshot, normalise, split into fields, BCD, then load all digits at once
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= IDLE;
            snapTime_r  <= 32'd0;
            snapDate_r  <= 1'b0;
            lastTime_r  <= 32'd0;
            lastDate_r  <= 1'b0;
            lastValid_r <= 1'b0;
            work_r      <= 17'd0;
            err_r       <= 1'b0;
            dispErr_r   <= 1'b0;
            dispValid_r <= 1'b0;
            busy        <= 1'b0;
            rangeErr    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                field_r[i] <= 7'd0;
                tens_r[i]  <= 4'd0;
            end
            for (int i = 0; i < 6; i++) begin
                digit_r[i] <= 4'd0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (changed_s) begin
                        snapTime_r <= timeIn;
                        snapDate_r <= dateMode;
                        busy       <= 1'b1;
                        state_r    <= NORM;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                NORM: begin
                    for (int i = 0; i < 3; i++) begin
                        tens_r[i] <= 4'd0;
                    end
                    if (snapDate_r) begin
                        err_r      <= dateErr_s;
                        field_r[0] <= snapTime_r[22:16];
                        field_r[1] <= snapTime_r[14:8];
                        field_r[2] <= snapTime_r[6:0];
                        state_r    <= dateErr_s ? LOAD : BCD;
                    end else begin
                        err_r      <= normErr_s;
                        work_r     <= normSec_s;
                        field_r[0] <= 7'd0;
                        field_r[1] <= 7'd0;
                        field_r[2] <= 7'd0;
                        state_r    <= normErr_s ? LOAD : HRS;
                    end
                end
                HRS: begin
                    if (work_r >= 17'(SEC_PER_HOUR)) begin
                        work_r     <= work_r - 17'(SEC_PER_HOUR);
                        field_r[0] <= field_r[0] + 7'd1;
                    end else begin
                        state_r    <= MINS;
                    end
                end
                MINS: begin
                    if (work_r >= 17'(SEC_PER_MIN)) begin
                        work_r     <= work_r - 17'(SEC_PER_MIN);
                        field_r[1] <= field_r[1] + 7'd1;
                    end else begin
                        field_r[2] <= work_r[6:0];
                        state_r    <= BCD;
                    end
                end
                BCD: begin
                    // All three fields peel off a ten in parallel to bound latency
                    if (bcdDone_s) begin
                        state_r <= LOAD;
                    end else begin
                        for (int i = 0; i < 3; i++) begin
                            if (field_r[i] >= 7'd10) begin
                                field_r[i] <= field_r[i] - 7'd10;
                                tens_r[i]  <= tens_r[i] + 4'd1;
                            end
                        end
                    end
                end
                LOAD: begin
                    digit_r[5]  <= tens_r[0];
                    digit_r[4]  <= field_r[0][3:0];
                    digit_r[3]  <= tens_r[1];
                    digit_r[2]  <= field_r[1][3:0];
                    digit_r[1]  <= tens_r[2];
                    digit_r[0]  <= field_r[2][3:0];
                    dispErr_r   <= err_r;
                    dispValid_r <= 1'b1;
                    rangeErr    <= err_r;
                    lastTime_r  <= snapTime_r;
                    lastDate_r  <= snapDate_r;
                    lastValid_r <= 1'b1;
                    busy        <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Blink phase generator, restarted visible on any edit-context change
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            blinkCnt_r   <= 32'd0;
            blinkVis_r   <= 1'b1;
            prevEdit_r   <= 2'd3;
            prevActive_r <= 1'b1;
        end else begin
            prevEdit_r   <= editStage;
            prevActive_r <= activeState;
            if ((editStage != prevEdit_r) || (activeState != prevActive_r)) begin
                blinkCnt_r <= 32'd0;
                blinkVis_r <= 1'b1;
            end else if (blinkCnt_r == 32'(BLINK_HALF_PERIOD - 1)) begin
                blinkCnt_r <= 32'd0;
                blinkVis_r <= ~blinkVis_r;
            end else begin
                blinkCnt_r <= blinkCnt_r + 32'd1;
            end
        end
    end

    genvar g;
    for (g = 0; g < 6; g++) begin : gDigit
        seg7_decode uDecode (
            .bcd (digit_r[g]),
            .seg (seg_s[g])
        );
    end

    // Digit pair under edit: stage 0 is the leftmost pair
    always_comb begin
        if (!activeState) begin
            case (editStage)
                2'd0:    editPair_s = 3'b100;
                2'd1:    editPair_s = 3'b010;
                2'd2:    editPair_s = 3'b001;
                default: editPair_s = 3'b000;
            endcase
        end else begin
            editPair_s = 3'b000;
        end
        digBlank_s = {{2{editPair_s[2]}}, {2{editPair_s[1]}}, {2{editPair_s[0]}}};
    end

    // Per-digit pattern selection; blanking outranks the dash pattern
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            if (!dispValid_r) begin
                hexNext_s[k] = SEG_BLANK;
            end else if (!blinkVis_r && (flashFlag || digBlank_s[k])) begin
                hexNext_s[k] = SEG_BLANK;
            end else if (dispErr_r) begin
                hexNext_s[k] = SEG_DASH;
            end else begin
                hexNext_s[k] = seg_s[k];
            end
        end
`ifdef DISPLAY_BLANK_LEAD_ZERO_EN
        if (!dispErr_r && (digit_r[5] == 4'd0)) begin
            hexNext_s[5] = SEG_BLANK;
        end else begin
            hexNext_s[5] = hexNext_s[5];
        end
`endif
    end

    // Registered segment outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            HEX0 <= SEG_BLANK;
            HEX1 <= SEG_BLANK;
            HEX2 <= SEG_BLANK;
            HEX3 <= SEG_BLANK;
            HEX4 <= SEG_BLANK;
            HEX5 <= SEG_BLANK;
        end else begin
            HEX0 <= hexNext_s[0];
            HEX1 <= hexNext_s[1];
            HEX2 <= hexNext_s[2];
            HEX3 <= hexNext_s[3];
            HEX4 <= hexNext_s[4];
            HEX5 <= hexNext_s[5];
        end
    end

endmodule

// File: doc/clock_display_driver.md
CLOCK_DISPLAY_DRIVER -- requirements
Module: clock_display_driver

Interface
REQ-001 BLINK_HALF_PERIOD, 25_000_000: Clk cycles per blink half-phase (0.5 s at 50 MHz); SHALL be >= 1.
REQ-002 Clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 Rst_n  in  1  reset; asynchronous and active-low.
REQ-004 timeIn  in  32  time mode: signed seconds-of-day; date mode: [23:16] day, [15:8] month, [7:0] year, all binary.
REQ-005 dateMode  in  1  1 = interpret timeIn as packed date.
REQ-006 activeState  in  1  1 = running display; 0 = field being edited.
REQ-007 editStage  in  2  edited field: 0 = hours/day (HEX5:4), 1 = minutes/month (HEX3:2), 2 = seconds/year (HEX1:0), 3 = none.
REQ-008 flashFlag  in  1  1 = all six digits blink.
REQ-009 HEX0..HEX5  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX5 is the leftmost digit.
REQ-010 busy  out  1  conversion in progress.
REQ-011 rangeErr  out  1  last converted value was out of range.

Function
REQ-012 FSM states SHALL be IDLE, NORM, HRS, MINS, BCD, LOAD.
REQ-013 IDLE SHALL snapshot {timeIn,dateMode} and go to NORM when the snapshot differs from the last converted value, or on the first cycle after reset; busy=1 from NORM through LOAD.
REQ-014 Inputs changing during a conversion SHALL NOT affect it; the change is detected on return to IDLE and reconverted.
REQ-015 NORM, time mode: value in [-86400,0) SHALL get +86400; [86400,172800) SHALL get -86400; outside [-86400,172800) SHALL set error and go to LOAD.
REQ-016 HRS SHALL subtract 3600 per cycle and count hours; MINS SHALL subtract 60 per cycle and count minutes; the remainder is seconds.
REQ-017 Date mode SHALL skip HRS/MINS; any field > 99 SHALL set error.
REQ-018 BCD SHALL convert each 0..99 field to tens/units by repeated subtract-10, one subtraction per cycle.
REQ-019 LOAD SHALL update all six digit registers and rangeErr in the same cycle, then return to IDLE; displayed digits SHALL never be a mix of old and new values.
REQ-020 Latency from leaving IDLE to LOAD completion SHALL be <= 120 cycles.
REQ-021 On error, all six HEX SHALL show a dash (7'h3F) and rangeErr=1; a later in-range conversion SHALL clear rangeErr.
REQ-022 A free-running blink counter SHALL toggle blink phase every BLINK_HALF_PERIOD cycles; phase SHALL restart "visible" whenever editStage or activeState changes.
REQ-023 Blanked phase: with activeState=0 and editStage<3, the selected digit pair SHALL be 7'h7F; with flashFlag=1, all digits SHALL be 7'h7F; all other digits stay steady.
REQ-024 flashFlag SHALL take priority over edit blinking; blanking SHALL also apply to the dash pattern.
REQ-025 Segment outputs SHALL be registered; a blink phase change SHALL reach HEX one cycle later.

Reset
REQ-026 Rst_n low SHALL immediately force HEX0..HEX5=7'h7F, busy=0, rangeErr=0, FSM=IDLE, blink counter=0, phase visible, and the last-converted record invalid.
REQ-027 Reset mid-conversion SHALL abort it; after release a fresh conversion SHALL start per REQ-013.

Configuration
REQ-028 Macro DISPLAY_BLANK_LEAD_ZERO_EN defined: in time mode HEX5 SHALL be blank (7'h7F) when hours < 10; in date mode HEX5 SHALL be blank when day < 10. Undefined: a leading zero SHALL be shown.

Structure
REQ-029 Package clock_disp_pkg SHALL hold SEC_PER_DAY=86400, SEC_PER_HOUR=3600, SEC_PER_MIN=60, the FSM state typedef, and segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
REQ-030 Sub-module seg7_decode SHALL map a 4-bit BCD value to active-low segments (0=7'h40 ... 9=7'h10) and SHALL be instantiated once per digit.

Verification
REQ-031 timeIn=45296, activeState=1 -> within 120 cycles HEX5..0 = 1,2,3,4,5,6; busy returns 0; rangeErr=0.
REQ-032 timeIn=32'hFFFFF1F0 (-3600) -> display 23:00:00; timeIn=86400 -> 00:00:00; timeIn=172800 -> all dashes, rangeErr=1; then timeIn=0 -> 00:00:00, rangeErr=0.
REQ-033 BLINK_HALF_PERIOD=4, activeState=0, editStage=1, timeIn=45296 -> HEX3/HEX2 alternate 3,4 / blank every 4 cycles; the other digits stay steady; flashFlag=1 -> all six digits blink together.
REQ-034 dateMode=1, timeIn=32'h00050B17 -> HEX5..0 = 0,5,1,1,2,3 (HEX5 blank with DISPLAY_BLANK_LEAD_ZERO_EN); day field 100 -> dashes.
REQ-035 timeIn changed from 45296 to 0 at cycle 3 of a conversion -> 12:34:56 is loaded first, then 00:00:00, with no mixed-digit cycle.
REQ-036 Rst_n pulsed low mid-conversion -> HEX=7'h7F and busy=0 asynchronously; after release the current timeIn is displayed within 120 cycles.
